// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the fetch / data / memory sides of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_gnt_o;
  logic                  if_rvalid_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic [BW-1:0]         dm_be_i;
  logic [ADDR_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic                  dm_gnt_o;
  logic                  dm_rvalid_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic [BW-1:0]         mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i,
    input  dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i,
    output dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data.
// Data has priority; a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [3:0]    lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wr_q, wr_d;

  logic resp;
  logic slot;
  logic starved;
  logic gnt_if;
  logic gnt_dm;

  assign resp    = rst && state_q == WAIT
                && lat_q == 4'd0;
  assign slot    = rst && (state_q == IDLE
                || lat_q == 4'd0);
  assign starved = starve_q == SW'(STARVE_LIMIT);

  // Fetch only beats a pending data request once starved.
  assign gnt_if = slot && bus.if_req_i
               && (!bus.dm_req_i || starved);
  assign gnt_dm = slot && bus.dm_req_i
               && !gnt_if;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    wr_d     = wr_q;
    if (resp) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      wr_d    = 1'b0;
    end else if (state_q == WAIT) begin
      lat_d = lat_q - 4'd1;
    end
    unique case (1'b1)
      gnt_if: begin
        state_d  = WAIT;
        owner_d  = OWN_IF;
        lat_d    = 4'(MEM_LATENCY - 1);
        wr_d     = 1'b0;
        starve_d = '0;
      end
      gnt_dm: begin
        state_d = WAIT;
        owner_d = OWN_DM;
        lat_d   = 4'(MEM_LATENCY - 1);
        wr_d    = bus.dm_we_i;
        if (!bus.if_req_i)
          starve_d = '0;
        else if (!starved)
          starve_d = starve_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= 4'd0;
      starve_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.if_gnt_o = gnt_if;
  assign bus.dm_gnt_o = gnt_dm;
  assign bus.mem_en_o = gnt_if | gnt_dm;
  assign bus.mem_we_o = gnt_dm & bus.dm_we_i;

  assign bus.mem_be_o =
    gnt_dm ? bus.dm_be_i : {BW{gnt_if}};

  assign bus.mem_addr_o =
    gnt_dm ? bus.dm_addr_i :
    gnt_if ? bus.if_addr_i : '0;

  assign bus.mem_wdata_o =
    gnt_dm ? bus.dm_wdata_i : '0;

  assign bus.if_rvalid_o =
    resp && owner_q == OWN_IF;
  assign bus.dm_rvalid_o =
    resp && owner_q == OWN_DM;

  assign bus.if_rdata_o =
    bus.if_rvalid_o ? bus.mem_rdata_i : '0;

  // Write completions carry no data.
  assign bus.dm_rdata_o =
    (bus.dm_rvalid_o && !wr_q)
      ? bus.mem_rdata_i : '0;

  assign bus.busy_o = rst && state_q == WAIT;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Two instances: MEM_LATENCY 1 and 3.
module tb_mem_port_arbiter;

  logic clk;
  logic rst1;
  logic rst3;

  int checks;
  int failures;

  logic [31:0] ifq1[$];
  logic [31:0] dmq1[$];
  logic [31:0] ifq3[$];

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

  mem_port_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) u1 (
    .clk(clk), .rst(rst1), .bus(b1.slave)
  );

  mem_port_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .MEM_LATENCY(3), .STARVE_LIMIT(4)
  ) u3 (
    .clk(clk), .rst(rst3), .bus(b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i < 128) return 32'hA000_0000 | 32'(i << 2);
    return 32'h0;
  endfunction

  // Memory for instance 1: latency 1, byte-enable writes.
  logic [31:0] m1 [0:255];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (!rst1) begin
      for (int i = 0; i < 256; i++) m1[i] <= init_word(i);
      rd1 <= 32'h0;
    end else if (b1.mem_en_o) begin
      if (b1.mem_we_o) begin
        for (int k = 0; k < 4; k++)
          if (b1.mem_be_o[k])
            m1[b1.mem_addr_o[9:2]][8*k +: 8] <= b1.mem_wdata_o[8*k +: 8];
      end
      rd1 <= m1[b1.mem_addr_o[9:2]];
    end else begin
      rd1 <= 32'h0;
    end
  end
  assign b1.mem_rdata_i = rd1;

  // Memory for instance 3: read-only, latency 3.
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= b3.mem_en_o ? init_word(int'(b3.mem_addr_o[9:2])) : 32'h0;
    p1 <= p0;
    p2 <= p1;
  end
  assign b3.mem_rdata_i = p2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitors: pop expectations whenever a response appears.
  always @(negedge clk) begin
    if (b1.if_rvalid_o) begin
      if (ifq1.size() == 0) chk("if1 unexpected rvalid", 1, 0);
      else chk("if1 rdata", b1.if_rdata_o, ifq1.pop_front());
    end else if (b1.if_rdata_o != 0) begin
      chk("if1 rdata idle", b1.if_rdata_o, 0);
    end
    if (b1.dm_rvalid_o) begin
      if (dmq1.size() == 0) chk("dm1 unexpected rvalid", 1, 0);
      else chk("dm1 rdata", b1.dm_rdata_o, dmq1.pop_front());
    end else if (b1.dm_rdata_o != 0) begin
      chk("dm1 rdata idle", b1.dm_rdata_o, 0);
    end
    if (b3.if_rvalid_o) begin
      if (ifq3.size() == 0) chk("if3 unexpected rvalid", 1, 0);
      else chk("if3 rdata", b3.if_rdata_o, ifq3.pop_front());
    end
    if (b3.dm_rvalid_o) chk("dm3 unexpected rvalid", 1, 0);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst1 = 1'b0;
    rst3 = 1'b0;
    b1.if_req_i   = 1'b1;
    b1.if_addr_i  = 32'h0;
    b1.dm_req_i   = 1'b1;
    b1.dm_we_i    = 1'b0;
    b1.dm_be_i    = 4'hF;
    b1.dm_addr_i  = 32'h100;
    b1.dm_wdata_i = 32'h0;
    b3.if_req_i   = 1'b0;
    b3.if_addr_i  = 32'h0;
    b3.dm_req_i   = 1'b0;
    b3.dm_we_i    = 1'b0;
    b3.dm_be_i    = 4'h0;
    b3.dm_addr_i  = 32'h0;
    b3.dm_wdata_i = 32'h0;

    // Reset with both requests high: everything quiet.
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rst ctl", {b1.if_gnt_o, b1.dm_gnt_o, b1.if_rvalid_o,
                      b1.dm_rvalid_o, b1.mem_en_o, b1.busy_o}, 0);
      chk("rst addr", b1.mem_addr_o, 0);
      step();
    end
    rst1 = 1'b1;
    dmq1.push_back(32'hA000_0100);
    ifq1.push_back(32'hA000_0000);

    // Contention: data first, fetch in the data response cycle.
    smp();
    chk("c0 gnt dm,if", {b1.dm_gnt_o, b1.if_gnt_o}, 2'b10);
    step();
    b1.dm_req_i = 1'b0;
    smp();
    chk("c1 gnt dm,if", {b1.dm_gnt_o, b1.if_gnt_o}, 2'b01);
    chk("c1 dm rvalid", b1.dm_rvalid_o, 1);
    chk("c1 fetch we,be,wdata", {b1.mem_we_o, b1.mem_be_o, b1.mem_wdata_o}, {1'b0, 4'hF, 32'h0});
    step();

    // Back-to-back fetches.
    b1.if_addr_i = 32'h4;
    ifq1.push_back(32'hA000_0004);
    smp();
    chk("c2 if gnt,rvalid", {b1.if_gnt_o, b1.if_rvalid_o}, 2'b11);
    chk("c2 mem addr", b1.mem_addr_o, 32'h4);
    step();
    b1.if_addr_i = 32'h8;
    ifq1.push_back(32'hA000_0008);
    smp();
    chk("c3 if gnt,rvalid", {b1.if_gnt_o, b1.if_rvalid_o}, 2'b11);
    step();
    b1.if_req_i = 1'b0;
    smp();
    chk("c4 if gnt,rvalid", {b1.if_gnt_o, b1.if_rvalid_o}, 2'b01);
    step();

    // Starvation: four data grants, one forced fetch, then data again.
    b1.dm_req_i  = 1'b1;
    b1.dm_addr_i = 32'h104;
    b1.if_req_i  = 1'b1;
    b1.if_addr_i = 32'hC;
    for (int i = 0; i < 5; i++) dmq1.push_back(32'hA000_0104);
    ifq1.push_back(32'hA000_000C);
    for (int i = 0; i < 6; i++) begin
      smp();
      chk($sformatf("starve gnt dm,if #%0d", i),
          {b1.dm_gnt_o, b1.if_gnt_o}, (i == 4) ? 2'b01 : 2'b10);
      step();
    end
    b1.dm_req_i = 1'b0;
    b1.if_req_i = 1'b0;
    smp();
    chk("c11 idle gnt", {b1.dm_gnt_o, b1.if_gnt_o}, 2'b00);
    step();

    // Partial write then read back.
    b1.dm_req_i   = 1'b1;
    b1.dm_we_i    = 1'b1;
    b1.dm_be_i    = 4'b0011;
    b1.dm_addr_i  = 32'h200;
    b1.dm_wdata_i = 32'hDEAD_BEEF;
    dmq1.push_back(32'h0);
    smp();
    chk("wr gnt", b1.dm_gnt_o, 1);
    chk("wr we,be,wdata", {b1.mem_we_o, b1.mem_be_o, b1.mem_wdata_o}, {1'b1, 4'b0011, 32'hDEAD_BEEF});
    step();
    b1.dm_we_i    = 1'b0;
    b1.dm_be_i    = 4'hF;
    b1.dm_wdata_i = 32'h0;
    dmq1.push_back(32'h0000_BEEF);
    smp();
    chk("rd gnt,rvalid", {b1.dm_gnt_o, b1.dm_rvalid_o}, 2'b11);
    step();
    b1.dm_req_i = 1'b0;
    smp();
    step();

    // Latency 3: reset drops the in-flight fetch.
    rst3 = 1'b1;
    b3.if_req_i  = 1'b1;
    b3.if_addr_i = 32'h8;
    smp();
    chk("l3 first gnt", b3.if_gnt_o, 1);
    step();
    b3.if_req_i = 1'b0;
    rst3 = 1'b0;
    smp();
    chk("l3 rst ctl", {b3.if_gnt_o, b3.if_rvalid_o, b3.mem_en_o, b3.busy_o}, 0);
    step();
    rst3 = 1'b1;
    b3.if_req_i  = 1'b1;
    b3.if_addr_i = 32'h4;
    ifq3.push_back(32'hA000_0004);
    smp();
    chk("l3 regrant gnt,busy", {b3.if_gnt_o, b3.busy_o}, 2'b10);
    chk("l3 regrant addr", b3.mem_addr_o, 32'h4);
    step();
    b3.if_req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      smp();
      chk($sformatf("l3 busy,rvalid +%0d", i), {b3.busy_o, b3.if_rvalid_o},
          (i < 3) ? 2'b10 : (i == 3) ? 2'b11 : 2'b00);
      step();
    end

    smp();
    chk("ifq1 drained", ifq1.size(), 0);
    chk("dmq1 drained", dmq1.size(), 0);
    chk("ifq3 drained", ifq3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
